apb_alu_completer: RTL and testbench

//  APB completer (slave) front-end for one ALU execution unit: the responder end of the controller's

---
 rtl/apb_alu_pkg.sv | 36 +++
 rtl/apb_alu_completer_alu_core.sv | 96 +++++++++
 rtl/apb_alu_completer.sv | 175 +++++++++++++++++
 tb/tb_apb_alu_completer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_alu_pkg.sv
// Shared types and constants for the APB ALU completer.
//   opcode_e    : ALU operation codes (CTRL[2:0])
//   OFF_*       : register byte offsets within the 8-bit window
//   STATUS_*    : bit positions within the STATUS register
//   fsm_state_e : APB response state machine encoding
package apb_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } opcode_e;

  localparam logic [7:0] OFF_OPA    = 8'h00;
  localparam logic [7:0] OFF_OPB    = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_RESULT = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;

  localparam int CTRL_START_BIT  = 8;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_FLAG_BIT = 2;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RESP      = 2'd1,
    S_WAIT_BUSY = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/apb_alu_completer_alu_core.sv
// ALU execution unit. Operands and opcode are captured on i_start; single-cycle
// ops finish one cycle after launch, MUL after MUL_CYCLES. The completion edge
// drops o_busy, updates o_result/o_flag and raises a one-cycle o_done.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_start           : launch request (ignored while busy)
//   i_op, i_a, i_b    : operation and operands sampled at launch
//   o_busy            : operation in flight
//   o_done            : one-cycle completion pulse
//   o_result, o_flag  : last result and carry/borrow/overflow flag
module alu_core
  import apb_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  opcode_e               i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_flag
);

  localparam int CNT_W = (MUL_CYCLES < 2) ? 1 : $clog2(MUL_CYCLES + 1);

  opcode_e               op_q;
  logic                  busy_q, done_q, flag_q, flag_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, result_q, result_d;
  logic [DATA_WIDTH:0]   sum, diff;
  logic [2*DATA_WIDTH-1:0] prod;

  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    // top bit of the extended difference is the borrow out
    diff     = {1'b0, a_q} - {1'b0, b_q};
    prod     = {{DATA_WIDTH{1'b0}}, a_q} * {{DATA_WIDTH{1'b0}}, b_q};
    result_d = '0;
    flag_d   = 1'b0;
    case (op_q)
      OP_ADD: begin result_d = sum[DATA_WIDTH-1:0];  flag_d = sum[DATA_WIDTH];  end
      OP_SUB: begin result_d = diff[DATA_WIDTH-1:0]; flag_d = diff[DATA_WIDTH]; end
      OP_AND: result_d = a_q & b_q;
      OP_OR:  result_d = a_q | b_q;
      OP_XOR: result_d = a_q ^ b_q;
      OP_SHL: result_d = a_q << b_q[4:0];
      OP_SHR: result_d = a_q >> b_q[4:0];
      OP_MUL: begin
        result_d = prod[DATA_WIDTH-1:0];
        flag_d   = |prod[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q     <= OP_ADD;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      flag_q   <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        // down-counter: terminal count 1 marks the completion edge
        if (cnt_q == CNT_W'(1)) begin
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= result_d;
          flag_q   <= flag_d;
        end
        cnt_q <= cnt_q - CNT_W'(1);
      end else if (i_start) begin
        busy_q <= 1'b1;
        op_q   <= i_op;
        a_q    <= i_a;
        b_q    <= i_b;
        cnt_q  <= (i_op == OP_MUL) ? CNT_W'(MUL_CYCLES) : CNT_W'(1);
      end
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;
  assign o_flag   = flag_q;

endmodule

// File: rtl/apb_alu_completer.sv
// APB completer front-end for one ALU unit: decodes its PSEL code, serves a
// five-register map and stalls RESULT reads while the ALU is busy.
//   i_PCLK, i_PRESET                       : clock, synchronous active-high reset
//   i_PSEL, i_PENABLE, i_PWRITE            : APB control (selected when i_PSEL == SLAVE_ID)
//   i_PADDR, i_PWDATA                      : address (offset = i_PADDR[7:0]) and write data
//   o_PREADY, o_PRDATA, o_PSLVERR          : registered one-cycle response
//   o_done                                 : ALU completion pulse
//
// state       | meaning
// S_IDLE      | waiting for an access phase
// S_RESP      | o_PREADY high for this single cycle
// S_WAIT_BUSY | RESULT read parked until the ALU finishes or the wait limit expires
module apb_alu_completer
  import apb_alu_pkg::*;
#(
  parameter int SEL_WIDTH    = 3,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SLAVE_ID     = 1,
  parameter int MUL_CYCLES   = 4,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic                  i_PCLK,
  input  logic                  i_PRESET,
  input  logic [SEL_WIDTH-1:0]  i_PSEL,
  input  logic                  i_PENABLE,
  input  logic                  i_PWRITE,
  input  logic [ADDR_WIDTH-1:0] i_PADDR,
  input  logic [DATA_WIDTH-1:0] i_PWDATA,
  output logic                  o_PREADY,
  output logic [DATA_WIDTH-1:0] o_PRDATA,
  output logic                  o_PSLVERR,
  output logic                  o_done
);

  localparam int TO_W = $clog2(WAIT_TIMEOUT + 1);

  fsm_state_e            state_q, state_d;
  logic                  pready_q, pready_d, pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [TO_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0] opa_q, opb_q, rd_val;
  logic [2:0]            ctrl_op_q;
  logic                  done_q;
  logic                  access, err, commit, start;
  logic [7:0]            offset;
  logic                  alu_busy, alu_done, alu_flag;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  unused_paddr_hi;

  assign unused_paddr_hi = ^i_PADDR[ADDR_WIDTH-1:8];
  assign access = (i_PSEL == SEL_WIDTH'(SLAVE_ID)) && i_PENABLE;
  assign offset = i_PADDR[7:0];
  // any write while busy is refused, so operands stay stable under an op
  assign err    = (offset[1:0] != 2'b00) || (offset > OFF_STATUS) ||
                  (i_PWRITE && ((offset == OFF_RESULT) || (offset == OFF_STATUS) || alu_busy));
  assign start  = commit && (offset == OFF_CTRL) && i_PWDATA[CTRL_START_BIT];

  always_comb begin
    rd_val = '0;
    case (offset)
      OFF_OPA:    rd_val = opa_q;
      OFF_OPB:    rd_val = opb_q;
      OFF_CTRL:   rd_val[2:0] = ctrl_op_q;
      OFF_RESULT: rd_val = alu_result;
      OFF_STATUS: begin
        rd_val[STATUS_BUSY_BIT] = alu_busy;
        // the pulse covers the cycle before the sticky bit catches up
        rd_val[STATUS_DONE_BIT] = done_q | alu_done;
        rd_val[STATUS_FLAG_BIT] = alu_flag;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    wait_cnt_d = wait_cnt_q;
    commit     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && !pready_q) begin
          if (!err && !i_PWRITE && (offset == OFF_RESULT) && alu_busy) begin
            state_d    = S_WAIT_BUSY;
            wait_cnt_d = TO_W'(WAIT_TIMEOUT);
          end else begin
            state_d   = S_RESP;
            pready_d  = 1'b1;
            pslverr_d = err;
            prdata_d  = (err || i_PWRITE) ? '0 : rd_val;
            commit    = i_PWRITE && !err;
          end
        end
      end
      S_RESP: state_d = S_IDLE;
      S_WAIT_BUSY: begin
        if (!access) begin
          state_d = S_IDLE;
        end else if (!alu_busy) begin
          state_d  = S_RESP;
          pready_d = 1'b1;
          prdata_d = alu_result;
        end else if (wait_cnt_q == TO_W'(1)) begin
          state_d   = S_RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      state_q    <= S_IDLE;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      opa_q     <= '0;
      opb_q     <= '0;
      ctrl_op_q <= '0;
      done_q    <= 1'b0;
    end else begin
      if (commit) begin
        case (offset)
          OFF_OPA:  opa_q     <= i_PWDATA;
          OFF_OPB:  opb_q     <= i_PWDATA;
          OFF_CTRL: ctrl_op_q <= i_PWDATA[2:0];
          default: ;
        endcase
      end
      if (start)         done_q <= 1'b0;
      else if (alu_done) done_q <= 1'b1;
    end
  end

  alu_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_alu_core (
    .i_clk   (i_PCLK),
    .i_rst   (i_PRESET),
    .i_start (start),
    .i_op    (opcode_e'(i_PWDATA[2:0])),
    .i_a     (opa_q),
    .i_b     (opb_q),
    .o_busy  (alu_busy),
    .o_done  (alu_done),
    .o_result(alu_result),
    .o_flag  (alu_flag)
  );

  assign o_PREADY  = pready_q;
  assign o_PRDATA  = prdata_q;
  assign o_PSLVERR = pslverr_q;
  assign o_done    = alu_done;

endmodule

// File: tb/tb_apb_alu_completer.sv
// Two completers share one APB bus: unit 1 with default timing, unit 2 with a
// short wait limit and slow MUL. A behavioural register/ALU model tracks unit 1.
module tb_apb_alu_completer;

  logic        clk = 1'b0;
  logic        preset;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        rdy0, err0, done0, rdy1, err1, done1;
  logic [31:0] rd0, rd1;

  always #5 clk = ~clk;

  apb_alu_completer #(
    .SEL_WIDTH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .SLAVE_ID(1), .MUL_CYCLES(4), .WAIT_TIMEOUT(16)
  ) u_dut0 (
    .i_PCLK(clk), .i_PRESET(preset), .i_PSEL(psel), .i_PENABLE(penable),
    .i_PWRITE(pwrite), .i_PADDR(paddr), .i_PWDATA(pwdata),
    .o_PREADY(rdy0), .o_PRDATA(rd0), .o_PSLVERR(err0), .o_done(done0)
  );

  apb_alu_completer #(
    .SEL_WIDTH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .SLAVE_ID(2), .MUL_CYCLES(8), .WAIT_TIMEOUT(2)
  ) u_dut1 (
    .i_PCLK(clk), .i_PRESET(preset), .i_PSEL(psel), .i_PENABLE(penable),
    .i_PWRITE(pwrite), .i_PADDR(paddr), .i_PWDATA(pwdata),
    .o_PREADY(rdy1), .o_PRDATA(rd1), .o_PSLVERR(err1), .o_done(done1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int stray = 0;
  int ndone0 = 0;
  logic prev_rdy0 = 1'b0, prev_rdy1 = 1'b0;

  // reference model state for unit 1
  logic [31:0] m_opa, m_opb, m_res;
  logic [2:0]  m_op;
  logic        m_done, m_flag;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // response hygiene: single-cycle PREADY, zero data/error when idle, no response to other codes
  always @(negedge clk) begin
    prev_rdy0 <= rdy0;
    prev_rdy1 <= rdy1;
    if (done0) ndone0 <= ndone0 + 1;
    if ((rdy0 && prev_rdy0) || (rdy1 && prev_rdy1) ||
        (!rdy0 && (rd0 != 32'h0 || err0)) || (!rdy1 && (rd1 != 32'h0 || err1)) ||
        (rdy0 && psel != 3'd1) || (rdy1 && psel != 3'd2))
      stray <= stray + 1;
  end

  task automatic apb(input logic [2:0] sel, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata,
                     output logic err, output int lat);
    logic got;
    int   bound;
    @(posedge clk); #1;
    psel = sel; pwrite = wr; paddr = addr; pwdata = wdata; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0; got = 1'b0; rdata = '0; err = 1'b0;
    bound = (sel == 3'd3) ? 8 : 64;
    while (!got && lat < bound) begin
      @(negedge clk);
      lat++;
      if (sel == 3'd1 && rdy0) begin got = 1'b1; rdata = rd0; err = err0; end
      else if (sel == 3'd2 && rdy1) begin got = 1'b1; rdata = rd1; err = err1; end
      else if (sel == 3'd3 && (rdy0 || rdy1)) got = 1'b1;
    end
    @(posedge clk); #1;
    psel = '0; penable = 1'b0; pwrite = 1'b0;
    chk_eq("ready_seen", {31'b0, got}, {31'b0, sel != 3'd3});
  endtask

  function automatic void model_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic f);
    longint unsigned wa, wb, w;
    wa = a; wb = b; f = 1'b0;
    case (op)
      3'd0: begin w = wa + wb; r = w[31:0]; f = (w >> 32) != 0; end
      3'd1: begin r = a - b; f = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[4:0];
      3'd6: r = a >> b[4:0];
      default: begin w = wa * wb; r = w[31:0]; f = (w >> 32) != 0; end
    endcase
  endfunction

  // expected response for unit 1 (caller guarantees the ALU is idle); updates the model on writes
  function automatic void model_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
    logic [7:0] off;
    off   = addr[7:0];
    err   = (off[1:0] != 2'b00) || (off > 8'h10) || (wr && (off == 8'h0C || off == 8'h10));
    rdata = '0;
    if (!err && !wr) begin
      case (off)
        8'h00: rdata = m_opa;
        8'h04: rdata = m_opb;
        8'h08: rdata = {29'b0, m_op};
        8'h0C: rdata = m_res;
        default: rdata = {29'b0, m_flag, m_done, 1'b0};
      endcase
    end else if (!err && wr) begin
      case (off)
        8'h00: m_opa = wdata;
        8'h04: m_opb = wdata;
        default: begin
          m_op = wdata[2:0];
          if (wdata[8]) begin
            model_alu(wdata[2:0], m_opa, m_opb, m_res, m_flag);
            m_done = 1'b1;
          end
        end
      endcase
    end
  endfunction

  task automatic model_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    logic [31:0] er, gr;
    logic        ee, ge;
    int          lat;
    model_access(wr, addr, wdata, er, ee);
    apb(3'd1, wr, addr, wdata, gr, ge, lat);
    chk_eq({tag, "_err"}, {31'b0, ge}, {31'b0, ee});
    chk_eq({tag, "_rdata"}, gr, er);
  endtask

  task automatic rd_exp(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] r; logic e; int lat;
    apb(sel, 1'b0, addr, 32'h0, r, e, lat);
    chk_eq({tag, "_err"}, {31'b0, e}, 32'h0);
    chk_eq(tag, r, exp);
  endtask

  task automatic wr_exp(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] data,
                        input logic exp_err, input string tag);
    logic [31:0] r; logic e; int lat;
    apb(sel, 1'b1, addr, data, r, e, lat);
    chk_eq(tag, {31'b0, e}, {31'b0, exp_err});
  endtask

  task automatic wait_idle(input logic [2:0] sel);
    logic [31:0] r; logic e; int lat, n;
    r = 32'h1; n = 0;
    while (r[0] && n < 40) begin
      apb(sel, 1'b0, 32'h10, 32'h0, r, e, lat);
      n++;
    end
    chk_eq("busy_clears", {31'b0, r[0]}, 32'h0);
  endtask

  initial begin
    logic [31:0] r, a, b, d, addr_tab [12];
    logic        e;
    int          lat, base;
    logic [2:0]  op;
    addr_tab = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                 32'h02, 32'h01, 32'h103, 32'h44, 32'hFC, 32'h108};
    preset = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    m_opa = '0; m_opb = '0; m_res = '0; m_op = '0; m_done = 1'b0; m_flag = 1'b0;
    repeat (3) @(posedge clk);
    #1 preset = 1'b0;
    @(negedge clk);
    chk_eq("rst_pready", {31'b0, rdy0}, 32'h0);
    chk_eq("rst_prdata", rd0, 32'h0);
    chk_eq("rst_pslverr", {31'b0, err0}, 32'h0);
    chk_eq("rst_done", {31'b0, done0}, 32'h0);

    // reset in the middle of a MUL aborts it
    model_xfer(1'b1, 32'h00, 32'h0001_0000, "t1_opa");
    model_xfer(1'b1, 32'h04, 32'h0001_0000, "t1_opb");
    wr_exp(3'd1, 32'h08, 32'h107, 1'b0, "t1_start");
    preset = 1'b1;
    @(negedge clk);
    chk_eq("midrst_pready", {31'b0, rdy0}, 32'h0);
    chk_eq("midrst_done", {31'b0, done0}, 32'h0);
    @(posedge clk); @(posedge clk);
    #1 preset = 1'b0;
    m_opa = '0; m_opb = '0; m_res = '0; m_op = '0; m_done = 1'b0; m_flag = 1'b0;
    base = ndone0;
    repeat (8) @(posedge clk);
    chk_eq("rst_no_done", ndone0 - base, 32'h0);
    rd_exp(3'd1, 32'h10, 32'h0, "rst_status");
    model_xfer(1'b0, 32'h0C, 32'h0, "rst_result");
    model_xfer(1'b0, 32'h00, 32'h0, "rst_opa");

    // ADD 7 + 5
    base = ndone0;
    model_xfer(1'b1, 32'h00, 32'd7, "t2_opa");
    model_xfer(1'b1, 32'h04, 32'd5, "t2_opb");
    model_xfer(1'b1, 32'h08, 32'h100, "t2_ctrl");
    wait_idle(3'd1);
    rd_exp(3'd1, 32'h0C, 32'h0000_000C, "t2_result");
    rd_exp(3'd1, 32'h10, 32'h2, "t2_status");
    chk_eq("t2_done_pulses", ndone0 - base, 32'h1);

    // carry and borrow
    model_xfer(1'b1, 32'h00, 32'hFFFF_FFFF, "t3_opa");
    model_xfer(1'b1, 32'h04, 32'h1, "t3_opb");
    model_xfer(1'b1, 32'h08, 32'h100, "t3_ctrl");
    wait_idle(3'd1);
    rd_exp(3'd1, 32'h0C, 32'h0, "t3_add_result");
    rd_exp(3'd1, 32'h10, 32'h6, "t3_add_status");
    model_xfer(1'b1, 32'h00, 32'h0, "t3_opa0");
    model_xfer(1'b1, 32'h08, 32'h101, "t3_sub");
    wait_idle(3'd1);
    rd_exp(3'd1, 32'h0C, 32'hFFFF_FFFF, "t3_sub_result");
    rd_exp(3'd1, 32'h10, 32'h6, "t3_sub_status");

    // MUL with wait states, then a write refused while busy
    model_xfer(1'b1, 32'h00, 32'h0001_0000, "t4_opa");
    model_xfer(1'b1, 32'h04, 32'h0001_0000, "t4_opb");
    model_xfer(1'b1, 32'h08, 32'h107, "t4_ctrl");
    apb(3'd1, 1'b0, 32'h0C, 32'h0, r, e, lat);
    chk_eq("t4_wait_states", {31'b0, lat > 1}, 32'h1);
    chk_eq("t4_result_err", {31'b0, e}, 32'h0);
    chk_eq("t4_result", r, 32'h0);
    rd_exp(3'd1, 32'h10, 32'h6, "t4_status");
    model_xfer(1'b1, 32'h08, 32'h107, "t4_restart");
    wr_exp(3'd1, 32'h00, 32'h1234, 1'b1, "t4_busy_write_err");
    wait_idle(3'd1);
    model_xfer(1'b0, 32'h00, 32'h0, "t4_opa_kept");

    // address/access errors leave registers untouched
    model_xfer(1'b0, 32'h14, 32'h0, "t5_rd14");
    model_xfer(1'b0, 32'h02, 32'h0, "t5_rd02");
    model_xfer(1'b1, 32'h0C, 32'hDEAD_BEEF, "t5_wr0c");
    model_xfer(1'b0, 32'h0C, 32'h0, "t5_result_kept");
    model_xfer(1'b0, 32'h04, 32'h0, "t5_opb_kept");

    // unit 2: wait limit expires before the slow MUL ends
    wr_exp(3'd2, 32'h00, 32'd3, 1'b0, "t6_opa");
    wr_exp(3'd2, 32'h04, 32'd5, 1'b0, "t6_opb");
    wr_exp(3'd2, 32'h08, 32'h107, 1'b0, "t6_ctrl");
    apb(3'd2, 1'b0, 32'h0C, 32'h0, r, e, lat);
    chk_eq("t6_timeout_err", {31'b0, e}, 32'h1);
    chk_eq("t6_timeout_rdata", r, 32'h0);
    wait_idle(3'd2);
    rd_exp(3'd2, 32'h0C, 32'd15, "t6_result");
    rd_exp(3'd2, 32'h10, 32'h2, "t6_status");
    apb(3'd3, 1'b0, 32'h10, 32'h0, r, e, lat);

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      a  = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      op = 3'($urandom_range(0, 7));
      model_xfer(1'b1, 32'h00, a, "rnd_opa");
      model_xfer(1'b1, 32'h04, b, "rnd_opb");
      model_xfer(1'b1, 32'h08, ($urandom & 32'hFFFF_FEF8) | 32'h100 | {29'b0, op}, "rnd_start");
      wait_idle(3'd1);
      model_xfer(1'b0, 32'h0C, 32'h0, "rnd_result");
      model_xfer(1'b0, 32'h10, 32'h0, "rnd_status");
      for (int j = 0; j < 2; j++) begin
        paddr = addr_tab[$urandom_range(0, 11)];
        d = $urandom;
        if (paddr[7:0] == 8'h08) d[8] = 1'b0;
        model_xfer(1'($urandom_range(0, 1)), paddr, d, "rnd_access");
      end
    end

    chk_eq("stray_outputs", stray, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
